// File: rtl/ff_apb_pkg.sv
// rtl/ff_apb_pkg.sv - shared constants and helpers for the APB master arbiter
package ff_apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam int FF_APB_ADDR_WIDTH = 20;
    localparam int FF_APB_DATA_WIDTH = 32;

    // Index width for n items, never less than one bit.
    function automatic int ff_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/ff_rr_arbiter.sv
// rtl/ff_rr_arbiter.sv - combinational round-robin picker, scans upward from ptr with wrap
module ff_rr_arbiter
    import ff_apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = ff_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = k + int'(ptr);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (idx == i) && req[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ff_apb_arbiter.sv
// rtl/ff_apb_arbiter.sv - round-robin APB master arbiter; FF_APB_ARB_PREADY_EN adds pready wait states
module ff_apb_arbiter
    import ff_apb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = FF_APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FF_APB_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata
`ifdef FF_APB_ARB_PREADY_EN
   ,input  logic                          pready
`endif
);

    localparam int IDX_W = ff_clog2(NUM_REQ);

    logic [1:0]            state, state_nxt;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  any_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_write;
    logic                  xfer_ok;
    logic                  done_now;

    ff_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

`ifdef FF_APB_ARB_PREADY_EN
    assign xfer_ok = pready;
`else
    assign xfer_ok = 1'b1;
`endif

    // A transfer that is being reset away must not be reported as complete.
    assign done_now = (state == ST_ACCESS) && xfer_ok && !reset;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt_oh  <= '0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                gnt_idx <= arb_idx;
                gnt_oh  <= arb_grant;
                paddr   <= sel_addr;
                pwdata  <= sel_wdata;
                pwrite  <= sel_write;
            end
            if (done_now)
                ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (xfer_ok) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        psel      = (state == ST_SETUP) || (state == ST_ACCESS);
        penable   = (state == ST_ACCESS);
        busy      = psel;
        req_done  = done_now ? gnt_oh : '0;
        rsp_rdata = done_now ? prdata : '0;
    end

endmodule

// File: tb/tb_ff_apb_arbiter.sv
// tb/tb_ff_apb_arbiter.sv - vector-table and directed-sequence bench for ff_apb_arbiter
module tb_ff_apb_arbiter;

    localparam int NR = 2;
    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_write;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    logic [NR-1:0] req_done;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    ff_apb_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  ({a1, a0}),
        .req_wdata ({w1, w0}),
        .req_done  (req_done),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata)
`ifdef FF_APB_ARB_PREADY_EN
       ,.pready    (pready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rw;
        logic [19:0] ia0;
        logic [19:0] ia1;
        logic [31:0] iw0;
        logic [31:0] iw1;
        logic [31:0] prd;
        logic        e_psel;
        logic        e_pen;
        logic        e_pwr;
        logic [19:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [1:0]  e_done;
        logic [31:0] e_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic [1:0] rv, input logic [1:0] rw,
        input logic [19:0] ia0, input logic [19:0] ia1,
        input logic [31:0] iw0, input logic [31:0] iw1, input logic [31:0] prd,
        input logic e_psel, input logic e_pen, input logic e_pwr,
        input logic [19:0] e_paddr, input logic [31:0] e_pwdata,
        input logic [1:0] e_done, input logic [31:0] e_rdata, input logic e_busy);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ia0 = ia0; v.ia1 = ia1; v.iw0 = iw0; v.iw1 = iw1; v.prd = prd;
        v.e_psel = e_psel; v.e_pen = e_pen; v.e_pwr = e_pwr; v.e_paddr = e_paddr;
        v.e_pwdata = e_pwdata; v.e_done = e_done; v.e_rdata = e_rdata; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single read, single write, then sustained contention with reissue
        vecs.push_back(mk(2'b01, 2'b00, 20'h10,  20'h0,   32'h0, 32'h0,        32'h0,        0,0,0, 20'h0,   32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b01, 2'b00, 20'h10,  20'h0,   32'h0, 32'h0,        32'h0,        1,0,0, 20'h10,  32'h0,        2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b01, 2'b00, 20'h10,  20'h0,   32'h0, 32'h0,        32'hDEADBEEF, 1,1,0, 20'h10,  32'h0,        2'b01, 32'hDEADBEEF, 1));
        vecs.push_back(mk(2'b00, 2'b00, 20'h10,  20'h0,   32'h0, 32'h0,        32'hDEADBEEF, 0,0,0, 20'h10,  32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b10, 2'b10, 20'h10,  20'h4,   32'h0, 32'hA5A50003, 32'h0,        0,0,0, 20'h10,  32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b10, 2'b10, 20'h10,  20'h4,   32'h0, 32'hA5A50003, 32'h0,        1,0,1, 20'h4,   32'hA5A50003, 2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b10, 2'b10, 20'h10,  20'h4,   32'h0, 32'hA5A50003, 32'h12345678, 1,1,1, 20'h4,   32'hA5A50003, 2'b10, 32'h12345678, 1));
        vecs.push_back(mk(2'b00, 2'b00, 20'h10,  20'h4,   32'h0, 32'h0,        32'h12345678, 0,0,1, 20'h4,   32'hA5A50003, 2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b11, 2'b00, 20'h100, 20'h200, 32'h0, 32'h0,        32'hCAFE0001, 0,0,1, 20'h4,   32'hA5A50003, 2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b11, 2'b00, 20'h100, 20'h200, 32'h0, 32'h0,        32'h0,        1,0,0, 20'h100, 32'h0,        2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h100, 20'h200, 32'h0, 32'h0,        32'hCAFE0001, 1,1,0, 20'h100, 32'h0,        2'b01, 32'hCAFE0001, 1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h200, 32'h0, 32'h0,        32'hCAFE0001, 0,0,0, 20'h100, 32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h200, 32'h0, 32'h0,        32'h0,        1,0,0, 20'h200, 32'h0,        2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h200, 32'h0, 32'h0,        32'hCAFE0002, 1,1,0, 20'h200, 32'h0,        2'b10, 32'hCAFE0002, 1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h204, 32'h0, 32'h0,        32'h0,        0,0,0, 20'h200, 32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h204, 32'h0, 32'h0,        32'h0,        1,0,0, 20'h104, 32'h0,        2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h104, 20'h204, 32'h0, 32'h0,        32'hCAFE0003, 1,1,0, 20'h104, 32'h0,        2'b01, 32'hCAFE0003, 1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h108, 20'h204, 32'h0, 32'h0,        32'h0,        0,0,0, 20'h104, 32'h0,        2'b00, 32'h0,        0));
        vecs.push_back(mk(2'b11, 2'b00, 20'h108, 20'h204, 32'h0, 32'h0,        32'h0,        1,0,0, 20'h204, 32'h0,        2'b00, 32'h0,        1));
        vecs.push_back(mk(2'b11, 2'b00, 20'h108, 20'h204, 32'h0, 32'h0,        32'hCAFE0004, 1,1,0, 20'h204, 32'h0,        2'b10, 32'hCAFE0004, 1));
        vecs.push_back(mk(2'b00, 2'b00, 20'h108, 20'h204, 32'h0, 32'h0,        32'h0,        0,0,0, 20'h204, 32'h0,        2'b00, 32'h0,        0));

        reset = 1'b1; req_valid = '0; req_write = '0;
        a0 = '0; a1 = '0; w0 = '0; w1 = '0; prdata = '0; pready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            req_valid = vecs[i].rv; req_write = vecs[i].rw;
            a0 = vecs[i].ia0; a1 = vecs[i].ia1; w0 = vecs[i].iw0; w1 = vecs[i].iw1;
            prdata = vecs[i].prd;
            #1;
            chk($sformatf("v%0d_psel", i),    64'(psel),      64'(vecs[i].e_psel));
            chk($sformatf("v%0d_penable", i), 64'(penable),   64'(vecs[i].e_pen));
            chk($sformatf("v%0d_pwrite", i),  64'(pwrite),    64'(vecs[i].e_pwr));
            chk($sformatf("v%0d_paddr", i),   64'(paddr),     64'(vecs[i].e_paddr));
            chk($sformatf("v%0d_pwdata", i),  64'(pwdata),    64'(vecs[i].e_pwdata));
            chk($sformatf("v%0d_req_done", i), 64'(req_done), 64'(vecs[i].e_done));
            chk($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vecs[i].e_rdata));
            chk($sformatf("v%0d_busy", i),    64'(busy),      64'(vecs[i].e_busy));
            tick();
        end

        // payload change during SETUP: bus keeps the latched address
        req_valid = 2'b01; req_write = 2'b00; a0 = 20'h20; prdata = 32'h0;
        tick();
        a0 = 20'h8; #1;
        chk("chg_setup_paddr", 64'(paddr), 64'h20);
        chk("chg_setup_psel", 64'({psel, penable}), 64'b10);
        tick();
        prdata = 32'h55AA55AA; #1;
        chk("chg_access_paddr", 64'(paddr), 64'h20);
        chk("chg_access_done", 64'(req_done), 64'b01);
        chk("chg_access_rdata", 64'(rsp_rdata), 64'h55AA55AA);
        req_valid = 2'b00;
        tick();
        chk("chg_after_done", 64'(req_done), 64'b00);
        chk("chg_after_psel", 64'(psel), 64'b0);

        // requester 1 drops req_valid mid-transfer; the latched transfer still completes
        req_valid = 2'b10; a1 = 20'h40; prdata = 32'h0;
        tick();
        req_valid = 2'b00; #1;
        chk("drop_setup_psel", 64'(psel), 64'b1);
        tick();
        chk("drop_access_done", 64'(req_done), 64'b10);
        chk("drop_access_paddr", 64'(paddr), 64'h40);
        tick();
        chk("drop_idle_done", 64'(req_done), 64'b00);

        // reset while in ACCESS, then the same request is served again
        req_valid = 2'b01; req_write = 2'b01; a0 = 20'h30; w0 = 32'h0BADF00D;
        tick();
        tick();
        chk("rst_in_access_pen", 64'(penable), 64'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("rst_psel_pen", 64'({psel, penable}), 64'b00);
        chk("rst_done", 64'(req_done), 64'b00);
        chk("rst_busy", 64'(busy), 64'b0);
        chk("rst_regs", 64'({pwrite, paddr, pwdata}), 64'b0);
        tick();
        chk("rst_reserve_setup", 64'({psel, penable, pwrite}), 64'b101);
        chk("rst_reserve_payload", 64'({paddr, pwdata}), 64'({20'h30, 32'h0BADF00D}));
        tick();
        chk("rst_reserve_done", 64'(req_done), 64'b01);
        req_valid = 2'b00; req_write = 2'b00;
        tick();

`ifdef FF_APB_ARB_PREADY_EN
        // three wait states: ACCESS held four cycles, done only with pready
        req_valid = 2'b10; req_write = 2'b10; a1 = 20'h50; w1 = 32'h77;
        tick();
        pready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wait%0d_ctl", k), 64'({psel, penable, pwrite}), 64'b111);
            chk($sformatf("wait%0d_payload", k), 64'({paddr, pwdata}), 64'({20'h50, 32'h77}));
            chk($sformatf("wait%0d_done", k), 64'(req_done), 64'b00);
            tick();
        end
        pready = 1'b1; prdata = 32'h0; #1;
        chk("wait_final_ctl", 64'({psel, penable}), 64'b11);
        chk("wait_final_done", 64'(req_done), 64'b10);
        req_valid = 2'b00;
        tick();
        chk("wait_idle", 64'({psel, penable, req_done}), 64'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_apb_arbiter.md
Name: ff_apb_arbiter

Overview:
- Shares the single APB master port of the flunkyfive APB fabric between NUM_REQ on-chip requesters, e.g. the host BFM path and a register-sequencer/DMA engine.
- Round-robin grants; one APB transfer in flight at a time.
- Each requester uses a simple hold-until-done request interface; the block drives paddr/psel/penable/pwrite/pwdata and returns prdata.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 20, APB address width
DATA_WIDTH, 32, APB data width

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester transfer request, held until req_done
req_write  input  NUM_REQ  per-requester 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
req_done  output  NUM_REQ  one-hot completion strobe
rsp_rdata  output  DATA_WIDTH  read data, valid while req_done is nonzero
busy  output  1  transfer in progress (SETUP or ACCESS)
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready; present only with FF_APB_ARB_PREADY_EN

Behaviour:
- States: IDLE, SETUP, ACCESS. Reset forces IDLE.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_done=0, busy=0, RR pointer=0 (requester 0 highest priority).
- IDLE:
  - If any req_valid, pick winner g: first set bit scanning from pointer upward, wrapping at NUM_REQ-1 to 0.
  - Latch addr/write/wdata of g into paddr/pwrite/pwdata; go to SETUP.
  - With no request, hold outputs; paddr/pwdata keep their last values.
- SETUP: psel=1, penable=0, one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - Transfer completes in this cycle: req_done[g]=1 and rsp_rdata=prdata (combinational pass-through; 0 when req_done=0). pwrite=1 transfers also pulse req_done.
  - On completion: pointer <= (g+1) mod NUM_REQ; next state IDLE.
- Latency: req_valid seen in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS/req_done cycle 2.
  - Minimum 3 cycles per transfer; one IDLE cycle between back-to-back transfers.
- Requester rule: hold req_valid and payload until it samples req_done, then drop or change req_valid the next cycle.
  - The arbiter re-arbitrates in IDLE after that edge, so a completed request is never replayed.
- Payload is latched at grant. If a requester drops req_valid or changes payload mid-transfer, the latched transfer still completes and req_done still pulses.
- Simultaneous requests: exactly one grant per IDLE cycle. With all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset mid-transfer: next edge returns to IDLE with psel/penable=0 and no req_done; the aborted requester is re-served normally once reset releases.
- busy=1 in SETUP and ACCESS.

Optional Feature:
FF_APB_ARB_PREADY_EN
- Defined:
  - pready port exists.
  - ACCESS is held (psel=1, penable=1, paddr/pwrite/pwdata stable) until pready=1.
  - req_done and rsp_rdata are asserted only in the ACCESS cycle where pready=1.
  - Pointer updates only then.
- Undefined: no pready port; every ACCESS is a single cycle (APB2 timing, matching the flunkyfive slave).

Decomposition:
- Package ff_apb_pkg holds:
  - state encoding localparams (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2)
  - default ADDR_WIDTH/DATA_WIDTH constants
  - a clog2 helper for index width
- Sub-module ff_rr_arbiter: combinational round-robin picker. Inputs are request vector and pointer; outputs are one-hot grant, grant index and any_req. Reusable elsewhere.

Test Plan:
- Single read: requester 0 reads 0x00010, slave returns 0xDEADBEEF -> psel cycle 1, penable cycle 2, req_done=2'b01 cycle 2, rsp_rdata=0xDEADBEEF.
- Single write: requester 1 writes 0xA5A5_0003 to 0x00004 -> paddr=0x00004, pwrite=1, pwdata=0xA5A5_0003 stable across SETUP/ACCESS; req_done=2'b10.
- Contention: both request from reset, each reissuing after done -> grant order 0,1,0,1; no requester waits more than one transfer.
- Payload change mid-transfer: requester 0 changes req_addr to 0x00008 during SETUP -> bus still shows originally latched address; req_done pulses once.
- Reset in ACCESS -> psel=penable=0 next cycle, no req_done; a later request completes normally.
- With FF_APB_ARB_PREADY_EN, pready low 3 cycles -> ACCESS held 4 cycles with signals stable; req_done only on the pready=1 cycle.
